router_pkt_fifo: RTL and testbench
==================================

ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data byte width (>=3).
REQ-002 SHALL have parameter DEPTH, default 16, entry count, power of 2 and >=4.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, level at or above which almost_full asserts.
REQ-004 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port soft_reset  input  1  synchronous active-high flush (per-channel timeout flush).
REQ-007 SHALL have port write_enb  input  1  write request.
REQ-008 SHALL have port data_in  input  DATA_W  write data.
REQ-009 SHALL have port lfd_state  input  1  marks data_in as a packet header byte.
REQ-010 SHALL have port read_enb  input  1  read request.
REQ-011 SHALL have port data_out  output  DATA_W  registered read data.
REQ-012 SHALL have port data_valid  output  1  data_out carries a byte popped last cycle.
REQ-013 SHALL have port sop_out  output  1  data_out byte is a header.
REQ-014 SHALL have port pkt_done  output  1  data_out byte is the last (parity) byte of a packet.
REQ-015 SHALL have ports empty, full, almost_full  output  1 each  occupancy flags.
REQ-016 SHALL have port level  output  clog2(DEPTH)+1  current entry count.
REQ-017 SHALL have port pkt_err  output  1  sticky framing-error flag.

Function
REQ-018 SHALL store DATA_W+1 bits per entry: data plus header flag captured from lfd_state.
REQ-019 SHALL accept a write iff write_enb=1 and full=0; write when full SHALL be dropped without state change.
REQ-020 SHALL accept a read iff read_enb=1 and empty=0; read when empty SHALL be ignored.
REQ-021 SHALL update pointers (mod DEPTH, natural wrap) and level on accepted operations; simultaneous accepted read+write SHALL leave level unchanged.
REQ-022 SHALL derive empty=(level==0), full=(level==DEPTH), almost_full=(level>=AFULL_TH) combinationally from the level register (zero flag lag).
REQ-023 SHALL present popped entry on data_out/sop_out one cycle after an accepted read with data_valid=1.
REQ-024 SHALL drive data_valid=0, sop_out=0, pkt_done=0 and data_out=0 in any cycle not following an accepted read; no tri-state output.
REQ-025 SHALL, on popping a header entry, load remaining counter with data[DATA_W-1:2]+1 (payload bytes plus parity).
REQ-026 SHALL decrement remaining on each popped non-header entry while remaining>0.
REQ-027 SHALL assert pkt_done with the popped non-header byte that takes remaining from 1 to 0.
REQ-028 SHALL set pkt_err on popping a header while remaining>0 (and still load new length), or popping a non-header while remaining==0.
REQ-029 SHALL treat header length 0 as a packet of one parity byte.
REQ-030 SHALL keep pkt_err set until resetn or soft_reset.

Reset
REQ-031 SHALL, on resetn=0 at a clock edge, clear pointers, level, remaining, pkt_err, data_out, data_valid, sop_out, pkt_done; empty=1, full=0, almost_full=0.
REQ-032 SHALL give soft_reset=1 identical effect to resetn=0; reset/soft_reset SHALL override any same-cycle read or write.
REQ-033 SHALL NOT require memory array contents to be cleared.

Verification
REQ-034 Reset: resetn=0 one edge with reads/writes active -> level=0, empty=1, data_valid=0, data_out=0x00.
REQ-035 Packet: write header 0x0C (lfd=1, length 3), 0x11,0x22,0x33, parity 0x5A; read 5 -> data_out 0x0C(sop_out=1),0x11,0x22,0x33,0x5A with pkt_done=1 only on 0x5A, pkt_err=0.
REQ-036 Full/wrap: write 16 bytes -> full=1, almost_full=1 at level 14; 17th write dropped; read all -> 16 bytes in order, empty=1; repeat across pointer wrap, order preserved.
REQ-037 Simultaneous: at level 16, read+write same cycle -> write dropped, level 15; at level 5 -> level stays 5.
REQ-038 Framing: header 0x08 then second header before parity byte popped -> pkt_err=1 and stays 1 until soft_reset.
REQ-039 Soft reset mid-packet: soft_reset after 2 of 5 bytes read -> level=0, empty=1, pkt_err=0; next packet reads cleanly.

Source files
------------

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet byte FIFO with header flag, occupancy flags and pop-side framing check
module router_pkt_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     lfd_state,
    input  logic                     read_enb,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     sop_out,
    output logic                     pkt_done,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     pkt_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_LVL = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-2:0] remaining;
    logic [DATA_W:0]   head;
    logic              clr, do_wr, do_rd;
    always_comb begin
        clr = !resetn || soft_reset;
        empty = level == '0;
        full = level == FULL_LVL;
        almost_full = level >= AF_LVL;
        do_wr = write_enb && !full;
        do_rd = read_enb && !empty;
        head = mem[rd_ptr];
    end
    always_ff @(posedge clock)
        if (do_wr && !clr) mem[wr_ptr] <= {lfd_state, data_in};
    always_ff @(posedge clock) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            remaining <= '0;
            pkt_err <= 1'b0;
            data_out <= '0;
            data_valid <= 1'b0;
            sop_out <= 1'b0;
            pkt_done <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_wr);
            rd_ptr <= rd_ptr + AW'(do_rd);
            level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
            data_out <= do_rd ? head[DATA_W-1:0] : '0;
            data_valid <= do_rd;
            sop_out <= do_rd && head[DATA_W];
            pkt_done <= do_rd && !head[DATA_W] && remaining == (DATA_W-1)'(1);
            // a header arriving mid-packet still restarts the length count
            if (do_rd && head[DATA_W]) begin
                remaining <= {1'b0, head[DATA_W-1:2]} + (DATA_W-1)'(1);
                if (remaining != '0) pkt_err <= 1'b1;
            end else if (do_rd) begin
                if (remaining == '0) pkt_err <= 1'b1;
                else remaining <= remaining - (DATA_W-1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: directed scenario tasks for router_pkt_fifo with inline expected values
module tb_router_pkt_fifo;
    logic       clock = 0, resetn = 0, soft_reset = 0, write_enb = 0, lfd_state = 0, read_enb = 0;
    logic [7:0] data_in = 0, data_out;
    logic       data_valid, sop_out, pkt_done, empty, full, almost_full, pkt_err;
    logic [4:0] level;
    int checks = 0, failures = 0;

    router_pkt_fifo dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .write_enb(write_enb),
        .data_in(data_in), .lfd_state(lfd_state), .read_enb(read_enb), .data_out(data_out),
        .data_valid(data_valid), .sop_out(sop_out), .pkt_done(pkt_done), .empty(empty),
        .full(full), .almost_full(almost_full), .level(level), .pkt_err(pkt_err)
    );

    always #5 clock = ~clock;

    // inputs change on the falling edge; outputs are sampled on the next falling edge
    task automatic cyc(input logic we, input logic [7:0] d, input logic lfd, input logic re);
        write_enb = we; data_in = d; lfd_state = lfd; read_enb = re;
        @(negedge clock);
        write_enb = 0; data_in = 0; lfd_state = 0; read_enb = 0;
    endtask

    task automatic srst();
        soft_reset = 1;
        @(negedge clock);
        soft_reset = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        resetn = 1;
        cyc(1, 8'h12, 0, 0);
        cyc(1, 8'h34, 0, 0);
        cyc(0, 8'h00, 0, 1);
        resetn = 0; write_enb = 1; read_enb = 1; data_in = 8'hFF;
        @(negedge clock);
        resetn = 1; write_enb = 0; read_enb = 0; data_in = 0;
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin failures++; $display("FAIL reset_full_af got=%b%b exp=00", full, almost_full); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
        checks++; if (sop_out !== 1'b0 || pkt_done !== 1'b0 || pkt_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b exp=000", sop_out, pkt_done, pkt_err); end
    endtask

    task automatic test_packet();
        logic [7:0] pk [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h5A};
        for (int i = 0; i < 5; i++) cyc(1, pk[i], i == 0, 0);
        checks++; if (level !== 5'd5) begin failures++; $display("FAIL pkt_level got=%0d exp=5", level); end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 8'h00, 0, 1);
            checks++; if (data_out !== pk[i] || data_valid !== 1'b1) begin failures++; $display("FAIL pkt_data[%0d] got=%h/%b exp=%h/1", i, data_out, data_valid, pk[i]); end
            checks++; if (sop_out !== (i == 0) || pkt_done !== (i == 4)) begin failures++; $display("FAIL pkt_marks[%0d] got sop=%b done=%b exp sop=%b done=%b", i, sop_out, pkt_done, i == 0, i == 4); end
        end
        checks++; if (pkt_err !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL pkt_end got err=%b empty=%b exp err=0 empty=1", pkt_err, empty); end
        cyc(0, 8'h00, 0, 0);
        checks++; if (data_valid !== 1'b0 || data_out !== 8'h00 || pkt_done !== 1'b0) begin failures++; $display("FAIL pkt_idle got=%b/%h/%b exp=0/00/0", data_valid, data_out, pkt_done); end
    endtask

    task automatic test_full_wrap();
        for (int r = 0; r < 2; r++) begin
            logic [7:0] base = r == 0 ? 8'h40 : 8'hA0;
            for (int i = 0; i < 16; i++) begin
                cyc(1, 8'(base + i), 0, 0);
                if (i == 12) begin
                    checks++; if (almost_full !== 1'b0 || level !== 5'd13) begin failures++; $display("FAIL wrap%0d_af13 got af=%b lvl=%0d exp af=0 lvl=13", r, almost_full, level); end
                end
                if (i == 13) begin
                    checks++; if (almost_full !== 1'b1 || level !== 5'd14 || full !== 1'b0) begin failures++; $display("FAIL wrap%0d_af14 got af=%b lvl=%0d full=%b exp af=1 lvl=14 full=0", r, almost_full, level, full); end
                end
            end
            checks++; if (full !== 1'b1 || level !== 5'd16) begin failures++; $display("FAIL wrap%0d_full got full=%b lvl=%0d exp full=1 lvl=16", r, full, level); end
            cyc(1, 8'hEE, 0, 0);
            checks++; if (full !== 1'b1 || level !== 5'd16) begin failures++; $display("FAIL wrap%0d_drop got full=%b lvl=%0d exp full=1 lvl=16", r, full, level); end
            for (int i = 0; i < 16; i++) begin
                cyc(0, 8'h00, 0, 1);
                checks++; if (data_out !== 8'(base + i) || data_valid !== 1'b1) begin failures++; $display("FAIL wrap%0d_rd[%0d] got=%h/%b exp=%h/1", r, i, data_out, data_valid, 8'(base + i)); end
            end
            checks++; if (empty !== 1'b1 || level !== 5'd0) begin failures++; $display("FAIL wrap%0d_empty got empty=%b lvl=%0d exp empty=1 lvl=0", r, empty, level); end
            cyc(0, 8'h00, 0, 1);
            checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL wrap%0d_rd_empty got valid=%b exp=0", r, data_valid); end
        end
        srst();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h60 + i), 0, 0);
        cyc(1, 8'h77, 0, 1);
        checks++; if (level !== 5'd15 || full !== 1'b0) begin failures++; $display("FAIL sim_full got lvl=%0d full=%b exp lvl=15 full=0", level, full); end
        checks++; if (data_out !== 8'h60) begin failures++; $display("FAIL sim_full_data got=%h exp=60", data_out); end
        srst();
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h80 + i), 0, 0);
        cyc(1, 8'h85, 0, 1);
        checks++; if (level !== 5'd5 || data_out !== 8'h80) begin failures++; $display("FAIL sim_mid got lvl=%0d data=%h exp lvl=5 data=80", level, data_out); end
        for (int i = 1; i < 6; i++) begin
            cyc(0, 8'h00, 0, 1);
            checks++; if (data_out !== 8'(8'h80 + i)) begin failures++; $display("FAIL sim_drain[%0d] got=%h exp=%h", i, data_out, 8'(8'h80 + i)); end
        end
        srst();
    endtask

    task automatic test_framing();
        cyc(1, 8'h08, 1, 0);
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h04, 1, 0);
        cyc(1, 8'h02, 0, 0);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);
        checks++; if (pkt_err !== 1'b0) begin failures++; $display("FAIL frm_pre got err=%b exp=0", pkt_err); end
        cyc(0, 8'h00, 0, 1);
        checks++; if (pkt_err !== 1'b1 || sop_out !== 1'b1 || data_out !== 8'h04) begin failures++; $display("FAIL frm_hdr got err=%b sop=%b data=%h exp err=1 sop=1 data=04", pkt_err, sop_out, data_out); end
        cyc(0, 8'h00, 0, 1);
        checks++; if (pkt_done !== 1'b0 || data_out !== 8'h02) begin failures++; $display("FAIL frm_body got done=%b data=%h exp done=0 data=02", pkt_done, data_out); end
        repeat (2) cyc(0, 8'h00, 0, 0);
        checks++; if (pkt_err !== 1'b1) begin failures++; $display("FAIL frm_sticky got err=%b exp=1", pkt_err); end
        srst();
        checks++; if (pkt_err !== 1'b0) begin failures++; $display("FAIL frm_clear got err=%b exp=0", pkt_err); end
    endtask

    task automatic test_soft_reset();
        logic [7:0] pk [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h5A};
        logic [7:0] nk [3] = '{8'h04, 8'hA1, 8'hB2};
        for (int i = 0; i < 5; i++) cyc(1, pk[i], i == 0, 0);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);
        soft_reset = 1; write_enb = 1; read_enb = 1; data_in = 8'h99;
        @(negedge clock);
        soft_reset = 0; write_enb = 0; read_enb = 0; data_in = 0;
        checks++; if (level !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL srst_level got lvl=%0d empty=%b exp lvl=0 empty=1", level, empty); end
        checks++; if (pkt_err !== 1'b0 || data_valid !== 1'b0 || data_out !== 8'h00) begin failures++; $display("FAIL srst_out got err=%b valid=%b data=%h exp 0/0/00", pkt_err, data_valid, data_out); end
        for (int i = 0; i < 3; i++) cyc(1, nk[i], i == 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 0, 1);
            checks++; if (data_out !== nk[i] || sop_out !== (i == 0) || pkt_done !== (i == 2)) begin failures++; $display("FAIL srst_pkt[%0d] got=%h sop=%b done=%b exp=%h sop=%b done=%b", i, data_out, sop_out, pkt_done, nk[i], i == 0, i == 2); end
        end
        checks++; if (pkt_err !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL srst_end got err=%b empty=%b exp err=0 empty=1", pkt_err, empty); end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_full_wrap();
        test_simultaneous();
        test_framing();
        test_soft_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
